// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: opcode values, default datapath sizes and the FSM encoding.
package cpu_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NREG_DEF  = 4;

    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exec_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps after start.
// Instantiated by alu_exec_stage only when MUL_EN is defined.
module alu_mul_seq
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;
    logic               done_q;
    logic [2*WIDTH-1:0] acc_d;

    // Add the shifted multiplicand when the current multiplier LSB is set.
    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, a};
                mplier_q <= b;
                cnt_q    <= '0;
                run_q    <= 1'b1;
            end else if (run_q) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops with registered result/flags and one-hot writeback enable.
// Define MUL_EN to build opcode A as an iterative multiplier (otherwise A behaves as a NOP).
module alu_exec_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREG  = NREG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_in,
    input  logic [3:0]              op,
    input  logic [$clog2(NREG)-1:0] rd,
    input  logic [WIDTH-1:0]        rd_q,
    input  logic [WIDTH-1:0]        rs_q,
    output logic                    en_out,
    output logic [WIDTH-1:0]        alu_out,
    output logic [NREG-1:0]         reg_en,
    output logic                    busy,
    output logic                    zf,
    output logic                    cf
);
    localparam int IW = $clog2(NREG);

    exec_state_t        state_q;
    logic               en_out_q;
    logic [WIDTH-1:0]   alu_out_q;
    logic [NREG-1:0]    reg_en_q;
    logic               zf_q;
    logic               cf_q;

    logic [WIDTH:0]     sum_d;
    logic [WIDTH:0]     diff_d;
    logic [WIDTH-1:0]   res_d;
    logic               cf_d;
    logic               wr_d;
    logic               upd_d;
    logic [NREG-1:0]    onehot_d;

    // Extra MSB carries the carry-out of the add and the borrow of the subtract.
    assign sum_d  = {1'b0, rd_q} + {1'b0, rs_q};
    assign diff_d = {1'b0, rd_q} - {1'b0, rs_q};

    always_comb begin
        res_d = '0;
        cf_d  = 1'b0;
        wr_d  = 1'b1;
        upd_d = 1'b1;
        case (op)
            OP_MOV: res_d = rs_q;
            OP_ADD: begin
                res_d = sum_d[WIDTH-1:0];
                cf_d  = sum_d[WIDTH];
            end
            OP_SUB: begin
                res_d = diff_d[WIDTH-1:0];
                cf_d  = diff_d[WIDTH];
            end
            OP_AND: res_d = rd_q & rs_q;
            OP_OR:  res_d = rd_q | rs_q;
            OP_XOR: res_d = rd_q ^ rs_q;
            OP_NOT: res_d = ~rs_q;
            OP_SHL: begin
                res_d = {rd_q[WIDTH-2:0], 1'b0};
                cf_d  = rd_q[WIDTH-1];
            end
            OP_SHR: begin
                res_d = {1'b0, rd_q[WIDTH-1:1]};
                cf_d  = rd_q[0];
            end
            OP_CMP: begin
                res_d = diff_d[WIDTH-1:0];
                cf_d  = diff_d[WIDTH];
                wr_d  = 1'b0;
            end
            // MUL never reaches this path when the multiplier is built; otherwise it is a NOP.
            OP_MUL: begin
                wr_d  = 1'b0;
                upd_d = 1'b0;
            end
            default: begin
                wr_d  = 1'b0;
                upd_d = 1'b0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_onehot
            assign onehot_d[gi] = (rd == IW'(gi));
        end
    endgenerate

`ifdef MUL_EN
    logic                busy_q;
    logic [IW-1:0]       rd_lat_q;
    logic                mul_start_d;
    logic                mul_done;
    logic [2*WIDTH-1:0]  mul_product;

    assign mul_start_d = (state_q == ST_IDLE) && en_in && (op == OP_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_d),
        .a       (rd_q),
        .b       (rs_q),
        .done    (mul_done),
        .product (mul_product)
    );

    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            en_out_q  <= 1'b0;
            alu_out_q <= '0;
            reg_en_q  <= '0;
            zf_q      <= 1'b0;
            cf_q      <= 1'b0;
`ifdef MUL_EN
            busy_q    <= 1'b0;
            rd_lat_q  <= '0;
`endif
        end else begin
            en_out_q <= 1'b0;
            reg_en_q <= '0;
            case (state_q)
                ST_IDLE: begin
`ifdef MUL_EN
                    if (mul_start_d) begin
                        state_q  <= ST_MUL;
                        busy_q   <= 1'b1;
                        rd_lat_q <= rd;
                    end else
`endif
                    if (en_in) begin
                        en_out_q <= 1'b1;
                        if (upd_d) begin
                            zf_q <= (res_d == '0);
                            cf_q <= cf_d;
                        end
                        if (wr_d) begin
                            alu_out_q <= res_d;
                            reg_en_q  <= onehot_d;
                        end
                    end
                end
`ifdef MUL_EN
                // en_in is ignored here; the result is registered the cycle after the last step.
                ST_MUL: begin
                    if (mul_done) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        en_out_q  <= 1'b1;
                        alu_out_q <= mul_product[WIDTH-1:0];
                        reg_en_q  <= NREG'(1) << rd_lat_q;
                        zf_q      <= (mul_product[WIDTH-1:0] == '0);
                        cf_q      <= |mul_product[2*WIDTH-1:WIDTH];
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign en_out  = en_out_q;
    assign alu_out = alu_out_q;
    assign reg_en  = reg_en_q;
    assign zf      = zf_q;
    assign cf      = cf_q;

endmodule
